// File: rtl/jtag_pkg.sv
// Shared JTAG types: IEEE 1149.1 TAP state encoding, the TAP transition
// function, and the shift-master FSM state type.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } master_state_t;

    // Next TAP state for one TCK rising edge with the given TMS.
    function automatic tap_state_t tap_next(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        nxt = TLR;
        case (state)
            TLR:        nxt = tms ? TLR       : RTI;
            RTI:        nxt = tms ? SELECT_DR : RTI;
            SELECT_DR:  nxt = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: nxt = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   nxt = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   nxt = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   nxt = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   nxt = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  nxt = tms ? SELECT_DR : RTI;
            SELECT_IR:  nxt = tms ? TLR       : CAPTURE_IR;
            CAPTURE_IR: nxt = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   nxt = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   nxt = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   nxt = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   nxt = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  nxt = tms ? SELECT_DR : RTI;
            default:    nxt = TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Shadow copy of the target TAP controller state, advanced on every TCK rise.
module jtag_tap_tracker
    import jtag_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_adv,
    input  logic       i_tms,
    output tap_state_t o_state
);

    tap_state_t r_state;

    // Step the TAP graph on the cycle that raises TCK, using the TMS being presented.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= TLR;
        end else if (i_adv) begin
            r_state <= tap_next(r_state, i_tms);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG host-side shift engine: issues up to DATA_W TCK cycles per command,
// driving TMS/TDI LSB first and capturing TDO on each TCK rise.
// Optional TAP state tracking: define JTAG_TAP_TRACK_EN to add the tap_state port.
module jtag_shift_master
    import jtag_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 6,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_tms,
    input  logic [DATA_W-1:0] cmd_tdi,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_tdo,
    output logic              busy,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
`ifdef JTAG_TAP_TRACK_EN
    ,
    output logic [3:0]        tap_state
`endif
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);

    master_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_tms_vec;
    logic [DATA_W-1:0] r_tdi_vec;
    logic [DATA_W-1:0] r_rsp_tdo;
    logic              r_rsp_valid;
    logic              r_busy;
    logic              r_tck;
    logic              r_tms;
    logic              r_tdi;

    logic [LEN_W-1:0]  w_len;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_last;

    // Clamp requested length to the vector width; locate the final bit.
    assign w_len     = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
    assign w_idx_nxt = r_idx + IDX_W'(1);
    assign w_last    = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));

    // Command/shift/response sequencer with all JTAG pins registered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_tms_vec   <= '0;
            r_tdi_vec   <= '0;
            r_rsp_tdo   <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_tms_vec <= cmd_tms;
                        r_tdi_vec <= cmd_tdi;
                        r_len     <= w_len;
                        r_rsp_tdo <= '0;
                        r_idx     <= '0;
                        r_tms     <= cmd_tms[0];
                        r_tdi     <= cmd_tdi[0];
                        r_cnt     <= CNT_RELOAD;
                        r_busy    <= 1'b1;
                        r_state   <= (w_len == '0) ? ST_DONE : ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == '0) begin
                        r_tck            <= 1'b1;
                        r_rsp_tdo[r_idx] <= tdo_i;
                        r_cnt            <= CNT_RELOAD;
                        r_state          <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == '0) begin
                        r_tck <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_tms   <= r_tms_vec[w_idx_nxt];
                            r_tdi   <= r_tdi_vec[w_idx_nxt];
                            r_cnt   <= CNT_RELOAD;
                            r_state <= ST_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_tdo   = r_rsp_tdo;
    assign busy      = r_busy;
    assign tck_o     = r_tck;
    assign tms_o     = r_tms;
    assign tdi_o     = r_tdi;

`ifdef JTAG_TAP_TRACK_EN
    logic       w_tck_rise;
    tap_state_t w_tap_state;

    assign w_tck_rise = (r_state == ST_LOW) && (r_cnt == '0);

    jtag_tap_tracker u_tap_tracker (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_adv   (w_tck_rise),
        .i_tms   (r_tms),
        .o_state (w_tap_state)
    );

    assign tap_state = w_tap_state;
`endif

endmodule

// File: doc/jtag_shift_master.md
Name: jtag_shift_master

Overview:
JTAG host-side engine that drives TCK/TMS/TDI and samples TDO, i.e. the initiator end of the TAP protocol served by the on-chip debug core. It accepts shift commands (up to DATA_W bits of TMS and TDI, LSB first) over a valid/ready interface. It generates TCK from sys_clk and returns the captured TDO bits over a valid/ready response channel. Used by on-chip test logic to script a target TAP (loopback testing of the debug path, external JTAG targets).

Parameters:
DATA_W, 32, max bits per command
LEN_W, 6, width of cmd_len; must hold DATA_W
CLK_DIV, 4, TCK half-period in sys_clk cycles; legal range >=1

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_len  in  LEN_W  number of TCK cycles to issue
cmd_tms  in  DATA_W  TMS bit per TCK, bit0 first
cmd_tdi  in  DATA_W  TDI bit per TCK, bit0 first
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_tdo  out  DATA_W  captured TDO, bit i = sample at TCK rise i; unused bits 0
busy  out  1  high from command accept until response handshake
tck_o  out  1  JTAG TCK
tms_o  out  1  JTAG TMS
tdi_o  out  1  JTAG TDI
tdo_i  in  1  JTAG TDO, changes after TCK fall
tap_state  out  4  tracked TAP state (JTAG_TAP_TRACK_EN only)

Behaviour:
- Clock/reset: one clock, sys_clk. sys_rst is asynchronous, active-high.
- Reset values: state IDLE; tck_o=0, tms_o=1, tdi_o=0, rsp_valid=0, rsp_tdo=0, busy=0, cmd_ready=1.
- cmd_ready = (state==IDLE), combinational.
- FSM IDLE -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
- IDLE, on accept:
  - Latch tms/tdi vectors; len = min(cmd_len, DATA_W).
  - Clear rsp_tdo; idx=0.
  - Drive tms_o=cmd_tms[0], tdi_o=cmd_tdi[0].
  - cnt=CLK_DIV-1; go to LOW.
- LOW: tck_o=0. When cnt==0:
  - tck_o<=1 and rsp_tdo[idx]<=tdo_i, sampled on the same edge.
  - Reload cnt; go to HIGH.
- HIGH: when cnt==0:
  - tck_o<=0.
  - If idx==len-1, go to DONE.
  - Else idx++, drive tms_o/tdi_o with bit idx+1, reload cnt, go to LOW.
- TMS/TDI change only on the TCK falling-edge cycle, so they are stable for the whole low phase. Each TCK phase lasts exactly CLK_DIV cycles.
- DONE: rsp_valid=1 until rsp_ready, then IDLE. On handshake cmd_ready returns the next cycle; there is no same-cycle re-accept. tms_o/tdi_o hold their last values while idle.
- Latency: accept to rsp_valid = 2*CLK_DIV*len + 1 cycles.
- cmd_len==0: accepted, no TCK, DONE on the next cycle with rsp_tdo=0.
- cmd_len>DATA_W: clamped to DATA_W.
- Backpressure: while in DONE, TCK stays low and no new command is accepted.
- Reset mid-shift: all outputs return to reset values immediately; no response is issued; a partial TCK high pulse is truncated.

Optional Feature:
Macro JTAG_TAP_TRACK_EN.
- Defined:
  - tap_state follows the IEEE 1149.1 16-state TAP graph, advanced with tms_o on every cycle that sets tck_o to 1.
  - Reset value is TEST_LOGIC_RESET.
- Not defined: tap_state port and tracker logic are absent.

Decomposition:
- Shared package jtag_pkg:
  - tap_state_t enum, 4 bits, IEEE encoding: TLR=F, RTI=C, SELECT_DR=7, CAPTURE_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPDATE_DR=5, SELECT_IR=4, CAPTURE_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPDATE_IR=D.
  - Function tap_next(state, tms).
  - Master FSM state enum.
- Sub-module jtag_tap_tracker: state register plus tap_next; instantiated only under JTAG_TAP_TRACK_EN.

Test Plan:
- Reset: assert sys_rst with cmd_valid=1 -> tck_o=0, tms_o=1, tdi_o=0, rsp_valid=0, cmd_ready=1 after release.
- TAP reset: len=5, tms=0x1F, CLK_DIV=4 -> 5 TCK pulses, each high/low exactly 4 cycles; tap_state=TLR. Then len=1, tms=0 -> RTI.
- Loopback: tdo_i tied to tdi_o, len=32, tdi=0xA5C30F1E -> rsp_tdo=0xA5C30F1E, rsp_valid 257 cycles after accept.
- Short/odd lengths: len=0 -> rsp next cycle, rsp_tdo=0, no TCK edge. len=40 -> exactly 32 pulses. len=3 loopback with tdi=0xFFFFFFFF -> rsp_tdo=0x7.
- Backpressure: rsp_ready low for 10 cycles -> rsp_valid and rsp_tdo stable, cmd_ready=0, tck_o=0, a pending cmd_valid is not accepted.
- Mid-shift reset: assert sys_rst after the 3rd TCK rise of a 16-bit command -> outputs go to reset values asynchronously, no rsp_valid; the next command runs normally.
